// File: rtl/fp_pkg.sv
// fp_pkg: FP32 field constants, flag vector and stage-1 register layout for fp32_norm_round
package fp_pkg;
  localparam int MAG_W = 28;
  localparam int EXP_W = 9;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] BIAS = 9'd127;
  localparam logic [EXP_W-1:0] EXP_MAX = 9'd255;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } fp_flags_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] e;
    logic [MAG_W-1:0] mag;
    logic sticky1;
    logic zero;
  } s1_reg_t;
endpackage

// File: rtl/fp32_norm_round_if.sv
// fp32_norm_round_if: IN_* beat (valid/ready, sign, exp, mag, sticky, LZA codes) and OUT_* result (valid/ready, result, flags)
interface fp32_norm_round_if;
  import fp_pkg::*;
  logic IN_VALID, IN_READY, IN_SIGN, IN_STICKY, OUT_VALID, OUT_READY;
  logic [EXP_W-1:0] IN_EXP;
  logic [MAG_W-1:0] IN_MAG;
  logic [3:0] IN_SHIFT2, IN_SHIFT1, IN_SHIFT0;
  logic [31:0] OUT_RESULT;
  fp_flags_t OUT_FLAGS;
  modport master (
    output IN_VALID, IN_SIGN, IN_EXP, IN_MAG, IN_STICKY, IN_SHIFT2, IN_SHIFT1, IN_SHIFT0, OUT_READY,
    input IN_READY, OUT_VALID, OUT_RESULT, OUT_FLAGS
  );
  modport slave (
    input IN_VALID, IN_SIGN, IN_EXP, IN_MAG, IN_STICKY, IN_SHIFT2, IN_SHIFT1, IN_SHIFT0, OUT_READY,
    output IN_READY, OUT_VALID, OUT_RESULT, OUT_FLAGS
  );
endinterface

// File: rtl/lza_shift_decode.sv
// lza_shift_decode: one-hot LZA codes shift2_i/shift1_i/shift0_i -> predicted left shift l_o (0..31)
module lza_shift_decode (
  input  logic [3:0] shift2_i,
  input  logic [3:0] shift1_i,
  input  logic [3:0] shift0_i,
  output logic [4:0] l_o
);
  logic unused;
  assign unused = ^{shift2_i[3:2], shift2_i[0], shift1_i[0], shift0_i[0]};
  assign l_o = {shift2_i[1], shift1_i[3] | shift1_i[2], shift1_i[3] | shift1_i[1],
                shift0_i[3] | shift0_i[2], shift0_i[3] | shift0_i[1]};
endmodule

// File: rtl/fp32_norm_round.sv
// fp32_norm_round: 2-stage FP32 normalize/round/pack; ports CLK, RST and the fp32_norm_round_if.slave beat bus
module fp32_norm_round
  import fp_pkg::*;
(
  input logic CLK,
  input logic RST,
  fp32_norm_round_if.slave io
);
  logic [4:0] l, leff;
  logic [EXP_W-1:0] lim, e2, ef;
  logic [MAG_W-1:0] m2;
  logic [24:0] sum;
  logic s1_v_q, s2_v_q, adv2, in_ready, corr, g, r, s, inc, ovf, inx, sub, unused;
  s1_reg_t s1_q, s1_d;
  logic [31:0] res_q, res_d;
  fp_flags_t flg_q, flg_d;
  lza_shift_decode u_lza (.shift2_i(io.IN_SHIFT2), .shift1_i(io.IN_SHIFT1), .shift0_i(io.IN_SHIFT0), .l_o(l));
  assign adv2 = !s2_v_q || io.OUT_READY;
  assign in_ready = !s1_v_q || adv2;
  assign io.IN_READY = in_ready;
  assign io.OUT_VALID = s2_v_q;
  assign io.OUT_RESULT = res_q;
  assign io.OUT_FLAGS = flg_q;
  assign unused = m2[MAG_W-1];
  // Left shift is clamped so E never drops below 1; anything smaller lands as subnormal.
  always_comb begin
    lim = io.IN_EXP - 9'd1;
    leff = ({4'd0, l} > lim) ? lim[4:0] : l;
    s1_d.sign = io.IN_SIGN;
    s1_d.e = io.IN_MAG[MAG_W-1] ? io.IN_EXP + 9'd1 : io.IN_EXP - {4'd0, leff};
    s1_d.mag = io.IN_MAG[MAG_W-1] ? io.IN_MAG >> 1 : io.IN_MAG << leff;
    s1_d.sticky1 = io.IN_STICKY | (io.IN_MAG[MAG_W-1] & io.IN_MAG[0]);
    s1_d.zero = io.IN_MAG == '0 && !io.IN_STICKY;
  end
  // sum[24] is the fraction carry-out (1.0 x 2^(E+1)); sum[23] is the hidden bit, clear means subnormal.
  always_comb begin
    corr = !s1_q.mag[26] && s1_q.mag[25] && s1_q.e > 9'd1;
    m2 = corr ? s1_q.mag << 1 : s1_q.mag;
    e2 = s1_q.e - {8'd0, corr};
    g = m2[2];
    r = m2[1];
    s = m2[0] | s1_q.sticky1;
    inc = g & (r | s | m2[3]);
    sum = {1'b0, m2[26:3]} + {24'd0, inc};
    ef = e2 + {8'd0, sum[24]};
    inx = g | r | s;
    ovf = ef >= EXP_MAX;
    sub = !(sum[24] | sum[23]);
    res_d = s1_q.zero ? {s1_q.sign, 31'd0} :
            ovf ? {s1_q.sign, 8'hFF, 23'd0} :
            {s1_q.sign, sub ? 8'd0 : ef[7:0], sum[FRAC_W-1:0]};
    flg_d = s1_q.zero ? 3'b000 : ovf ? 3'b101 : {1'b0, sub & inx, inx};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (in_ready) s1_v_q <= io.IN_VALID;
      if (adv2) s2_v_q <= s1_v_q;
      if (adv2 && s1_v_q) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end
  end
  always_ff @(posedge CLK) if (io.IN_VALID && in_ready) s1_q <= s1_d;
endmodule

// File: tb/tb_fp32_norm_round.sv
// tb_fp32_norm_round: directed vectors, backpressure and mid-flight reset checks for fp32_norm_round
module tb_fp32_norm_round;
  import fp_pkg::*;
  localparam logic [3:0] C0 = 4'b0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  fp32_norm_round_if io ();
  fp32_norm_round dut (.CLK(clk), .RST(rst), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && io.OUT_VALID && io.OUT_READY) got_q.push_back(io.OUT_RESULT);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(logic sg, logic [8:0] e, logic [27:0] m, logic st, logic [3:0] c2, logic [3:0] c1, logic [3:0] c0);
    io.IN_VALID = 1'b1;
    io.IN_SIGN = sg;
    io.IN_EXP = e;
    io.IN_MAG = m;
    io.IN_STICKY = st;
    io.IN_SHIFT2 = c2;
    io.IN_SHIFT1 = c1;
    io.IN_SHIFT0 = c0;
  endtask

  task automatic run_vec(string tag, logic sg, logic [8:0] e, logic [27:0] m, logic st,
                         logic [3:0] c2, logic [3:0] c1, logic [3:0] c0, logic [31:0] res, logic [2:0] fl);
    @(negedge clk);
    drive(sg, e, m, st, c2, c1, c0);
    check({tag, ".rdy"}, 32'(io.IN_READY), 32'd1);
    @(negedge clk);
    io.IN_VALID = 1'b0;
    check({tag, ".lat"}, 32'(io.OUT_VALID), 32'd0);
    @(negedge clk);
    check({tag, ".vld"}, 32'(io.OUT_VALID), 32'd1);
    check({tag, ".res"}, io.OUT_RESULT, res);
    check({tag, ".flg"}, {29'd0, io.OUT_FLAGS}, {29'd0, fl});
    exp_q.push_back(res);
  endtask

  initial begin
    io.OUT_READY = 1'b1;
    drive(1'b0, 9'd0, 28'd0, 1'b0, C0, C0, C0);
    io.IN_VALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.vld", 32'(io.OUT_VALID), 32'd0);
    check("rst.rdy", 32'(io.IN_READY), 32'd1);
    check("rst.res", io.OUT_RESULT, 32'd0);
    check("rst.flg", {29'd0, io.OUT_FLAGS}, 32'd0);
    run_vec("one",     1'b0, BIAS,  28'h4000000, 1'b0, C0, C0, C0, 32'h3F800000, 3'b000);
    run_vec("tieodd",  1'b0, BIAS,  28'h400000C, 1'b0, C0, C0, C0, 32'h3F800002, 3'b001);
    run_vec("tieeven", 1'b0, BIAS,  28'h4000004, 1'b0, C0, C0, C0, 32'h3F800000, 3'b001);
    run_vec("sticky",  1'b0, BIAS,  28'h4000000, 1'b1, C0, C0, C0, 32'h3F800000, 3'b001);
    run_vec("lza1",    1'b0, BIAS,  28'h0800000, 1'b0, C0, C0, 4'b0100, 32'h3E000000, 3'b000);
    run_vec("lza9",    1'b0, BIAS,  28'h0010000, 1'b0, C0, 4'b0100, 4'b0010, 32'h3A800000, 3'b000);
    run_vec("ovf",     1'b0, 9'd254, 28'h8000000, 1'b0, C0, C0, C0, 32'h7F800000, 3'b101);
    run_vec("den",     1'b0, 9'd1,  28'h0000008, 1'b0, C0, C0, C0, 32'h00000001, 3'b000);
    run_vec("clamp",   1'b0, 9'd5,  28'h0000100, 1'b0, 4'b0010, C0, 4'b0100, 32'h00000200, 3'b000);
    run_vec("unf",     1'b1, 9'd1,  28'h0000006, 1'b0, C0, C0, C0, 32'h80000001, 3'b011);
    run_vec("sub2nrm", 1'b0, 9'd1,  28'h3FFFFFC, 1'b0, C0, C0, C0, 32'h00800000, 3'b001);
    run_vec("carry",   1'b0, BIAS,  28'h7FFFFFC, 1'b0, C0, C0, C0, 32'h40000000, 3'b001);
    run_vec("rsh",     1'b0, BIAS,  28'h8000001, 1'b0, C0, C0, C0, 32'h40000000, 3'b001);
    run_vec("zero",    1'b1, 9'd100, 28'h0000000, 1'b0, C0, C0, C0, 32'h80000000, 3'b000);
    @(negedge clk);
    io.OUT_READY = 1'b0;
    drive(1'b0, 9'd127, 28'h4000000, 1'b0, C0, C0, C0);
    check("bp.rdyA", 32'(io.IN_READY), 32'd1);
    @(negedge clk);
    drive(1'b0, 9'd128, 28'h4000000, 1'b0, C0, C0, C0);
    check("bp.rdyB", 32'(io.IN_READY), 32'd1);
    @(negedge clk);
    drive(1'b0, 9'd129, 28'h4000000, 1'b0, C0, C0, C0);
    check("bp.rdyC", 32'(io.IN_READY), 32'd0);
    check("bp.vld", 32'(io.OUT_VALID), 32'd1);
    check("bp.outA", io.OUT_RESULT, 32'h3F800000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.hold", io.OUT_RESULT, 32'h3F800000);
      check("bp.stall", 32'(io.IN_READY), 32'd0);
    end
    io.OUT_READY = 1'b1;
    #1;
    check("bp.rdycomb", 32'(io.IN_READY), 32'd1);
    @(negedge clk);
    io.IN_VALID = 1'b0;
    check("bp.outB", io.OUT_RESULT, 32'h40000000);
    @(negedge clk);
    check("bp.outC", io.OUT_RESULT, 32'h40800000);
    check("bp.vldC", 32'(io.OUT_VALID), 32'd1);
    @(negedge clk);
    check("bp.empty", 32'(io.OUT_VALID), 32'd0);
    exp_q.push_back(32'h3F800000);
    exp_q.push_back(32'h40000000);
    exp_q.push_back(32'h40800000);
    io.OUT_READY = 1'b0;
    drive(1'b0, 9'd130, 28'h4000000, 1'b0, C0, C0, C0);
    @(negedge clk);
    drive(1'b0, 9'd131, 28'h4000000, 1'b0, C0, C0, C0);
    @(negedge clk);
    io.IN_VALID = 1'b0;
    check("rs.full", 32'(io.OUT_VALID), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs.vld", 32'(io.OUT_VALID), 32'd0);
    check("rs.rdy", 32'(io.IN_READY), 32'd1);
    check("rs.res", io.OUT_RESULT, 32'd0);
    io.OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rs.nostale", 32'(io.OUT_VALID), 32'd0);
    end
    run_vec("post", 1'b0, BIAS, 28'h4000000, 1'b0, C0, C0, C0, 32'h3F800000, 3'b000);
    repeat (2) @(negedge clk);
    check("sb.count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("sb.order", got_q[i], exp_q[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
